data_mem_responder: RTL and testbench

//  Data-memory responder for the pipeline's execute-stage load/store request port.

---
 rtl/data_mem_responder.sv | 170 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the execute-stage load/store port: owns the data RAM,
// inserts configurable read/write wait states, returns a one-cycle load valid and a busy stall.
module data_mem_responder #(
   parameter int A_SIZE  = 10,
   parameter int D_SIZE  = 32,
   parameter int DEPTH   = 1024,
   parameter int RD_WAIT = 0,
   parameter int WR_WAIT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [A_SIZE-1:0] req_addr,
   input  logic [D_SIZE-1:0] req_wdata,
   input  logic              req_wen,
   input  logic              req_ren,
   output logic [D_SIZE-1:0] rsp_rdata,
   output logic              rsp_valid,
   output logic              busy,
   output logic              err
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // The 4-bit wait counter must never wrap, and the RAM must fit the address space.
   if (RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15 ||
       DEPTH < 1 || DEPTH > (2 ** A_SIZE)) begin : g_bad_param
      $error("data_mem_responder: illegal RD_WAIT/WR_WAIT/DEPTH parameter");
   end

   typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [A_SIZE-1:0]   addr_q, addr_d;
   logic [D_SIZE-1:0]   wdata_q, wdata_d;
   logic [D_SIZE-1:0]   rdata_q;
   logic                rsp_valid_q, rsp_valid_d;
   logic                err_q, err_d;

   logic                mem_we;
   logic [A_SIZE-1:0]   wr_addr;
   logic [D_SIZE-1:0]   wr_data;
   logic                rd_en;
   logic [A_SIZE-1:0]   rd_addr;
   logic                last_wait;

   logic [D_SIZE-1:0]   mem [0:DEPTH-1];

   function automatic logic in_range(input logic [A_SIZE-1:0] a);
      return {1'b0, a} < (A_SIZE + 1)'(DEPTH);
   endfunction

   assign last_wait = (cnt_q <= 4'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_wen) begin
               if (WR_WAIT != 0) begin
                  state_d = WR_BUSY;
                  cnt_d   = 4'(WR_WAIT);
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
               end
            end else if (req_ren) begin
               if (RD_WAIT != 0) begin
                  state_d = RD_BUSY;
                  cnt_d   = 4'(RD_WAIT);
                  addr_d  = req_addr;
               end
            end
         end
         RD_BUSY, WR_BUSY: begin
            if (last_wait) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Errors are flagged in the cycle after acceptance, independent of wait states.
   always_comb begin
      mem_we      = 1'b0;
      wr_addr     = req_addr;
      wr_data     = req_wdata;
      rd_en       = 1'b0;
      rd_addr     = req_addr;
      rsp_valid_d = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_wen) begin
               err_d  = req_ren | ~in_range(req_addr);
               mem_we = (WR_WAIT == 0) && in_range(req_addr);
            end else if (req_ren) begin
               err_d = ~in_range(req_addr);
               if (RD_WAIT == 0) begin
                  rd_en       = 1'b1;
                  rsp_valid_d = 1'b1;
               end
            end
         end
         RD_BUSY: begin
            if (last_wait) begin
               rd_en       = 1'b1;
               rd_addr     = addr_q;
               rsp_valid_d = 1'b1;
            end
         end
         WR_BUSY: begin
            if (last_wait) begin
               mem_we  = in_range(addr_q);
               wr_addr = addr_q;
               wr_data = wdata_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_addr[IW-1:0]] <= wr_data;
      end
   end

   // Registered read; out-of-range loads return zero rather than aliasing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= in_range(rd_addr) ? mem[rd_addr[IW-1:0]] : '0;
      end
   end

   assign rsp_rdata = rdata_q;
   assign rsp_valid = rsp_valid_q;
   assign busy      = (state_q != IDLE);
   assign err       = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: instance A has no wait states, instance B has RD_WAIT=3, WR_WAIT=2, DEPTH=512.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [9:0]  a_addr = '0, b_addr = '0;
   logic [31:0] a_wdata = '0, b_wdata = '0;
   logic        a_wen = 1'b0, a_ren = 1'b0, b_wen = 1'b0, b_ren = 1'b0;
   logic [31:0] a_rdata, b_rdata;
   logic        a_valid, a_busy, a_err, b_valid, b_busy, b_err;

   int vec_cnt = 0;
   int miss_cnt = 0;

   always #5 clk = ~clk;

   data_mem_responder #(.A_SIZE(10), .D_SIZE(32), .DEPTH(1024), .RD_WAIT(0), .WR_WAIT(0)) u_a (
      .clk(clk), .reset(rst_n), .req_addr(a_addr), .req_wdata(a_wdata),
      .req_wen(a_wen), .req_ren(a_ren), .rsp_rdata(a_rdata), .rsp_valid(a_valid),
      .busy(a_busy), .err(a_err));

   data_mem_responder #(.A_SIZE(10), .D_SIZE(32), .DEPTH(512), .RD_WAIT(3), .WR_WAIT(2)) u_b (
      .clk(clk), .reset(rst_n), .req_addr(b_addr), .req_wdata(b_wdata),
      .req_wen(b_wen), .req_ren(b_ren), .rsp_rdata(b_rdata), .rsp_valid(b_valid),
      .busy(b_busy), .err(b_err));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         miss_cnt++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic b_stat(input string tag, input logic busy_e, input logic valid_e, input logic err_e);
      chk({tag, "_busy"}, {31'd0, b_busy}, {31'd0, busy_e});
      chk({tag, "_valid"}, {31'd0, b_valid}, {31'd0, valid_e});
      chk({tag, "_err"}, {31'd0, b_err}, {31'd0, err_e});
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_a_valid", {31'd0, a_valid}, 32'd0);
      chk("rst_a_busy", {31'd0, a_busy}, 32'd0);
      chk("rst_a_err", {31'd0, a_err}, 32'd0);
      chk("rst_a_rdata", a_rdata, 32'd0);
      chk("rst_b_busy", {31'd0, b_busy}, 32'd0);
      chk("rst_b_rdata", b_rdata, 32'd0);
      tick(); tick();
      rst_n = 1'b1;

      // A: write DEADBEEF@5 then read @5
      a_wen = 1'b1; a_addr = 10'd5; a_wdata = 32'hDEADBEEF;
      tick();
      chk("a_wr_busy", {31'd0, a_busy}, 32'd0);
      chk("a_wr_novalid", {31'd0, a_valid}, 32'd0);
      a_wen = 1'b0; a_ren = 1'b1;
      tick();
      chk("a_rd_valid", {31'd0, a_valid}, 32'd1);
      chk("a_rd_data", a_rdata, 32'hDEADBEEF);
      chk("a_rd_busy", {31'd0, a_busy}, 32'd0);
      a_ren = 1'b0;
      tick();
      chk("a_valid_drop", {31'd0, a_valid}, 32'd0);
      chk("a_rdata_hold", a_rdata, 32'hDEADBEEF);

      // A: back-to-back reads
      a_wen = 1'b1; a_addr = 10'd1; a_wdata = 32'h11; tick();
      a_addr = 10'd2; a_wdata = 32'h22; tick();
      a_wen = 1'b0; a_ren = 1'b1; a_addr = 10'd1; tick();
      chk("a_b2b1_valid", {31'd0, a_valid}, 32'd1);
      chk("a_b2b1_data", a_rdata, 32'h11);
      a_addr = 10'd2; tick();
      chk("a_b2b2_valid", {31'd0, a_valid}, 32'd1);
      chk("a_b2b2_data", a_rdata, 32'h22);
      a_ren = 1'b0; tick();

      // A: wen & ren together
      a_wen = 1'b1; a_ren = 1'b1; a_addr = 10'd3; a_wdata = 32'hA; tick();
      chk("a_wr_rd_err", {31'd0, a_err}, 32'd1);
      chk("a_wr_rd_novalid", {31'd0, a_valid}, 32'd0);
      a_wen = 1'b0; a_ren = 1'b0; tick();
      chk("a_err_drop", {31'd0, a_err}, 32'd0);
      a_ren = 1'b1; tick();
      chk("a_rd3_valid", {31'd0, a_valid}, 32'd1);
      chk("a_rd3_data", a_rdata, 32'hA);
      chk("a_rd3_err", {31'd0, a_err}, 32'd0);
      a_ren = 1'b0; tick();

      // B: write 0x12@7 with two wait cycles
      b_wen = 1'b1; b_addr = 10'd7; b_wdata = 32'h12; tick();
      b_stat("b_w7_c1", 1'b1, 1'b0, 1'b0);
      b_wen = 1'b0; tick();
      b_stat("b_w7_c2", 1'b1, 1'b0, 1'b0);
      tick();
      b_stat("b_w7_done", 1'b0, 1'b0, 1'b0);

      // B: read @7 held through busy; re-accepted in the rsp_valid cycle
      b_ren = 1'b1; tick();
      b_stat("b_r7_c1", 1'b1, 1'b0, 1'b0);
      tick();
      b_stat("b_r7_c2", 1'b1, 1'b0, 1'b0);
      tick();
      b_stat("b_r7_c3", 1'b1, 1'b0, 1'b0);
      tick();
      b_stat("b_r7_rsp", 1'b0, 1'b1, 1'b0);
      chk("b_r7_data", b_rdata, 32'h12);
      tick();
      b_stat("b_r7_again", 1'b1, 1'b0, 1'b0);
      b_ren = 1'b0; tick(); tick(); tick();
      b_stat("b_r7b_rsp", 1'b0, 1'b1, 1'b0);
      chk("b_r7b_data", b_rdata, 32'h12);
      tick();

      // B: write 0x55@9 then read back
      b_wen = 1'b1; b_addr = 10'd9; b_wdata = 32'h55; tick();
      b_stat("b_w9_c1", 1'b1, 1'b0, 1'b0);
      b_wen = 1'b0; tick();
      b_stat("b_w9_c2", 1'b1, 1'b0, 1'b0);
      tick();
      b_stat("b_w9_done", 1'b0, 1'b0, 1'b0);
      b_ren = 1'b1; tick();
      b_ren = 1'b0; tick(); tick(); tick();
      b_stat("b_r9_rsp", 1'b0, 1'b1, 1'b0);
      chk("b_r9_data", b_rdata, 32'h55);
      tick();

      // B: reset mid-write discards the pending store
      b_wen = 1'b1; b_addr = 10'd9; b_wdata = 32'h66; tick();
      b_wen = 1'b0; tick();
      rst_n = 1'b0; #1;
      b_stat("b_rstw", 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      b_ren = 1'b1; b_addr = 10'd9; tick();
      b_ren = 1'b0; tick(); tick(); tick();
      b_stat("b_r9_after_rst", 1'b0, 1'b1, 1'b0);
      chk("b_r9_keep_data", b_rdata, 32'h55);
      tick();

      // B: reset mid-read, one wait cycle elapsed
      b_ren = 1'b1; b_addr = 10'd7; tick();
      chk("b_rstr_busy0", {31'd0, b_busy}, 32'd1);
      b_ren = 1'b0; tick();
      rst_n = 1'b0; #1;
      b_stat("b_rstr", 1'b0, 1'b0, 1'b0);
      chk("b_rstr_rdata", b_rdata, 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         b_stat("b_rstr_after", 1'b0, 1'b0, 1'b0);
      end

      // B: out-of-range write leaves aliased location intact
      b_wen = 1'b1; b_addr = 10'd88; b_wdata = 32'h44; tick();
      b_wen = 1'b0; tick(); tick();
      b_wen = 1'b1; b_addr = 10'd600; b_wdata = 32'h99; tick();
      b_stat("b_w600_c1", 1'b1, 1'b0, 1'b1);
      b_wen = 1'b0; tick();
      b_stat("b_w600_c2", 1'b1, 1'b0, 1'b0);
      tick();
      b_ren = 1'b1; b_addr = 10'd88; tick();
      b_ren = 1'b0; tick(); tick(); tick();
      b_stat("b_r88_rsp", 1'b0, 1'b1, 1'b0);
      chk("b_r88_data", b_rdata, 32'h44);
      tick();

      // B: out-of-range read returns zero with normal latency
      b_ren = 1'b1; b_addr = 10'd600; tick();
      b_stat("b_r600_c1", 1'b1, 1'b0, 1'b1);
      b_ren = 1'b0; tick();
      b_stat("b_r600_c2", 1'b1, 1'b0, 1'b0);
      tick();
      b_stat("b_r600_c3", 1'b1, 1'b0, 1'b0);
      tick();
      b_stat("b_r600_rsp", 1'b0, 1'b1, 1'b0);
      chk("b_r600_data", b_rdata, 32'd0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
